// File: rtl/mem_arbiter.sv
// Round-robin two-master (CPU/DMA) sequencer for the shared memory bus.
// Optional CPU bus lock for read-modify-write sequences: define MEM_ARB_LOCK_EN.
//
// state  | meaning
// IDLE   | no owner, arbitrate pending requests
// ACCESS | bus regs driven to memory for WAIT_STATES+1 cycles
// ACK    | one-cycle ack to owner, bus strobes low
module mem_arbiter #(
  parameter int WAIT_STATES = 2,
  parameter int AW          = 19,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_be,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_be,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic          mem_be,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       last_dma;
  logic       lock_q;
  logic       any_req;
  logic       pick_cpu;

  assign any_req  = cpu_req | dma_req;
  // Locked CPU beats a pending DMA; otherwise the master that did not go last wins.
  assign pick_cpu = cpu_req & (~dma_req | lock_q | last_dma);

`ifdef MEM_ARB_LOCK_EN
  logic bus_lock;

  // Lock is sampled with the rest of the request and takes effect once that access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_lock <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      if (state == IDLE && any_req && pick_cpu)
        bus_lock <= cpu_lock;
      if (state == ACK && gnt[0])
        lock_q <= bus_lock;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = cpu_lock;
  assign lock_q      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      last_dma  <= 1'b1;
      gnt       <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_be    <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ACCESS;
            wait_cnt <= WS_LOAD;
            if (pick_cpu) begin
              gnt       <= 2'b01;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_be    <= cpu_be;
              mem_we    <= cpu_we;
              mem_re    <= ~cpu_we;
            end else begin
              gnt       <= 2'b10;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              mem_be    <= dma_be;
              mem_we    <= dma_we;
              mem_re    <= ~dma_we;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state  <= ACK;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (gnt[0]) begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end else begin
              dma_rdata <= mem_rdata;
              dma_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          state    <= IDLE;
          last_dma <= gnt[1];
          gnt      <= 2'b00;
        end
        default: begin
          state  <= IDLE;
          gnt    <= 2'b00;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when driven
// and checked against bus activity and acks; build with MEM_ARB_LOCK_EN for the lock variant.
module tb_mem_arbiter;
  localparam int WS = 2;
  localparam int AW = 19;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_be, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          dma_req, dma_we, dma_be;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, mem_be;
  logic [1:0]    gnt;

  mem_arbiter #(.WAIT_STATES(WS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be), .gnt(gnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one fixed word, everything else derived from the address.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a == 19'h00100) ? 16'h1234 : (a[15:0] ^ 16'ha5a5);
  endfunction
  assign mem_rdata = exp_rd(mem_addr);

  typedef struct {
    bit            dma;
    logic          we;
    logic          be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            ack_cyc;
  } xact_t;

  xact_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else n_pass++;
  endtask

  task automatic push(input bit dma, input logic we, input logic be,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int ack_cyc);
    xact_t t;
    t.dma = dma; t.we = we; t.be = be; t.addr = addr; t.wd = wd; t.ack_cyc = ack_cyc;
    sb.push_back(t);
  endtask

  task automatic drive_cpu(input logic we, input logic be, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_lock = lock; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic drive_dma(input logic we, input logic be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    dma_req = 1'b1; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wd;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ack(output bit got_cpu, output bit got_dma);
    got_cpu = 1'b0;
    got_dma = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cpu_ack || dma_ack) begin
        got_cpu = cpu_ack;
        got_dma = dma_ack;
        return;
      end
    end
    chk("ack_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: bus contents and ack timing against the scoreboard head.
  xact_t e;
  int run_len = 0;
  logic [DW-1:0] exp_cpu_rd, exp_dma_rd;
  bit cpu_rd_ok, dma_rd_ok;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
        exp_cpu_rd = '0; exp_dma_rd = '0;
        cpu_rd_ok = 1'b1; dma_rd_ok = 1'b1;
      end else begin
        if (mem_re || mem_we) begin
          if (sb.size() == 0) chk("spurious_access", 32'd1, 32'd0);
          else begin
            e = sb[0];
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_re", 32'(mem_re), 32'(!e.we));
            chk("mem_be", 32'(mem_be), 32'(e.be));
            if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
            chk("gnt_access", 32'(gnt), e.dma ? 32'd2 : 32'd1);
          end
          run_len++;
        end
        if (cpu_ack || dma_ack) begin
          if (sb.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("ack_master", {30'd0, dma_ack, cpu_ack}, e.dma ? 32'd2 : 32'd1);
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            chk("access_len", 32'(run_len), 32'(WS + 1));
            chk("gnt_ack", 32'(gnt), e.dma ? 32'd2 : 32'd1);
            chk("strobes_ack", {30'd0, mem_we, mem_re}, 32'd0);
            if (e.dma) begin
              if (!e.we) begin
                exp_dma_rd = exp_rd(e.addr);
                dma_rd_ok = 1'b1;
                chk("dma_rdata", 32'(dma_rdata), 32'(exp_dma_rd));
              end else dma_rd_ok = 1'b0;
              if (cpu_rd_ok) chk("cpu_rdata_kept", 32'(cpu_rdata), 32'(exp_cpu_rd));
            end else begin
              if (!e.we) begin
                exp_cpu_rd = exp_rd(e.addr);
                cpu_rd_ok = 1'b1;
                chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
              end else cpu_rd_ok = 1'b0;
              if (dma_rd_ok) chk("dma_rdata_kept", 32'(dma_rdata), 32'(exp_dma_rd));
            end
          end
          run_len = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n_ack;
    bit gc, gd;
    bit cpu_second;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_be = 0; dma_addr = '0; dma_wdata = '0;
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_strobes", {29'd0, mem_we, mem_re, mem_be}, 32'd0);
    chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    rst_n = 1'b1;
    step();

    // Both masters held from reset: CPU first, then alternate.
    c = cyc;
    drive_cpu(1'b0, 1'b0, 1'b0, 19'h00040, 16'h0000);
    drive_dma(1'b1, 1'b0, 19'h00300, 16'h0dd0);
    push(1'b0, 1'b0, 1'b0, 19'h00040, 16'h0000, c + 4);
    push(1'b1, 1'b1, 1'b0, 19'h00300, 16'h0dd0, c + 9);
    push(1'b0, 1'b0, 1'b0, 19'h00040, 16'h0000, c + 14);
    push(1'b1, 1'b1, 1'b0, 19'h00300, 16'h0dd0, c + 19);
    repeat (4) wait_ack(gc, gd);
    cpu_req = 1'b0; dma_req = 1'b0;

    // CPU read of the fixed word.
    step();
    c = cyc;
    drive_cpu(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0000);
    push(1'b0, 1'b0, 1'b0, 19'h00100, 16'h0000, c + WS + 2);
    wait_ack(gc, gd);
    cpu_req = 1'b0;

    // CPU word write.
    step();
    c = cyc;
    drive_cpu(1'b1, 1'b0, 1'b0, 19'h00200, 16'hbeef);
    push(1'b0, 1'b1, 1'b0, 19'h00200, 16'hbeef, c + WS + 2);
    wait_ack(gc, gd);
    cpu_req = 1'b0;

    // CPU byte read; address wiggled mid-access must not reach the bus.
    step();
    c = cyc;
    drive_cpu(1'b0, 1'b1, 1'b0, 19'h0ff91, 16'h0000);
    push(1'b0, 1'b0, 1'b1, 19'h0ff91, 16'h0000, c + WS + 2);
    step();
    cpu_addr = 19'h00007;
    cpu_be = 1'b0;
    wait_ack(gc, gd);
    cpu_req = 1'b0;

    // Reset in the second ACCESS cycle of a DMA write.
    step();
    c = cyc;
    drive_dma(1'b1, 1'b0, 19'h00400, 16'hcafe);
    push(1'b1, 1'b1, 1'b0, 19'h00400, 16'hcafe, c + WS + 2);
    step();
    step();
    rst_n = 1'b0;
    dma_req = 1'b0;
    sb.delete();
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    n_ack = 0;
    repeat (6) begin
      step();
      if (cpu_ack || dma_ack) n_ack++;
    end
    chk("abort_no_ack", 32'(n_ack), 32'd0);

    // Locked CPU read followed by CPU write while DMA waits.
    step();
    c = cyc;
    drive_cpu(1'b0, 1'b0, 1'b1, 19'h00500, 16'h0000);
    drive_dma(1'b1, 1'b0, 19'h00600, 16'h6666);
    push(1'b0, 1'b0, 1'b0, 19'h00500, 16'h0000, c + 4);
`ifdef MEM_ARB_LOCK_EN
    push(1'b0, 1'b1, 1'b0, 19'h00500, 16'h5a5a, c + 9);
    push(1'b1, 1'b1, 1'b0, 19'h00600, 16'h6666, c + 14);
`else
    push(1'b1, 1'b1, 1'b0, 19'h00600, 16'h6666, c + 9);
    push(1'b0, 1'b1, 1'b0, 19'h00500, 16'h5a5a, c + 14);
`endif
    cpu_second = 1'b0;
    repeat (3) begin
      wait_ack(gc, gd);
      if (gc && !cpu_second) begin
        drive_cpu(1'b1, 1'b0, 1'b0, 19'h00500, 16'h5a5a);
        cpu_second = 1'b1;
      end else if (gc) cpu_req = 1'b0;
      if (gd) dma_req = 1'b0;
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    repeat (4) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
